// File: rtl/window_scheduler_if.sv
// window_scheduler_if: loader-side and tracker-side signals of the window scheduler.
// master = scheduler, slave = loader / match engine / downstream tracker.
//
// Handshakes: a result transfers on a cycle where tile_valid and tile_ready are
// both high. Once tile_valid rises it stays high and tile_x/tile_y/best_* stay
// constant until that transfer. wh_en is held high until the cycle wh_ack is seen.
// match_valid carries one score per cycle and has no back-pressure.
interface window_scheduler_if #(
   parameter int ADDR_W  = 20,
   parameter int SCORE_W = 24
);
   logic               wh_en;
   logic               wh_ack;
   logic               wh_done;
   logic [6:0]         wh_row;
   logic [6:0]         wh_col;
   logic [ADDR_W-1:0]  mem_addr;
   logic               match_valid;
   logic [SCORE_W-1:0] match_score;
   logic               tile_valid;
   logic               tile_ready;
   logic [7:0]         tile_x;
   logic [7:0]         tile_y;
   logic [6:0]         best_row;
   logic [6:0]         best_col;
   logic [SCORE_W-1:0] best_score;

   modport master (
      output wh_en, mem_addr, tile_valid, tile_x, tile_y, best_row, best_col, best_score,
      input  wh_ack, wh_done, wh_row, wh_col, match_valid, match_score, tile_ready
   );

   modport slave (
      input  wh_en, mem_addr, tile_valid, tile_x, tile_y, best_row, best_col, best_score,
      output wh_ack, wh_done, wh_row, wh_col, match_valid, match_score, tile_ready
   );
endinterface

// File: rtl/window_scheduler.sv
// window_scheduler: walks the frame tile by tile, drives the window loader,
// forms fetch addresses, tracks the minimum match score per tile and hands each
// tile result to the tracker.
// Optional feature macro: WINDOW_SCHEDULER_STATS_EN adds frame/stall cycle counters.
module window_scheduler #(
   parameter int TILES_X    = 4,
   parameter int TILES_Y    = 4,
   parameter int ROW_STRIDE = 320,
   parameter int ADDR_W     = 20,
   parameter int SCORE_W    = 24
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic        busy,
   output logic        frame_done,
   output logic        err,
   output logic [2:0]  dbg_state,
`ifdef WINDOW_SCHEDULER_STATS_EN
   output logic [31:0] stat_frame_cycles,
   output logic [31:0] stat_stall_cycles,
`endif
   window_scheduler_if.master bus
);
   localparam logic [12:0]       PATCHES  = 13'd4225;
   localparam logic [6:0]        LAST_POS = 7'd64;
   localparam logic [7:0]        LAST_TX  = 8'(TILES_X - 1);
   localparam logic [7:0]        LAST_TY  = 8'(TILES_Y - 1);
   localparam logic [ADDR_W-1:0] TILE_ROW_STEP = ADDR_W'(80 * ROW_STRIDE);
   localparam logic [ADDR_W-1:0] TILE_COL_STEP = ADDR_W'(20);
   localparam logic [ADDR_W-1:0] STRIDE        = ADDR_W'(ROW_STRIDE);

   typedef enum logic [2:0] {
      S_IDLE, S_REQ, S_FILL, S_DRAIN, S_RESULT, S_NEXT
   } state_t;

   state_t             state;
   logic [ADDR_W-1:0]  base_q;
   logic [12:0]        cnt;
   logic [6:0]         pos_row;
   logic [6:0]         pos_col;
   logic               busy_q;
   logic               frame_done_q;
   logic               err_q;
   logic               wh_en_q;
   logic               tile_valid_q;
   logic [7:0]         tile_x_q;
   logic [7:0]         tile_y_q;
   logic [6:0]         best_row_q;
   logic [6:0]         best_col_q;
   logic [SCORE_W-1:0] best_score_q;

   logic               last_x;
   logic               last_tile;
   logic [7:0]         nx_x;
   logic [7:0]         nx_y;
   logic               accept_st;
   logic               score_take;
   logic               score_bad;

   // Next tile index and score acceptance decode.
   always_comb begin
      last_x     = (tile_x_q == LAST_TX);
      last_tile  = last_x && (tile_y_q == LAST_TY);
      nx_x       = last_x ? 8'd0 : tile_x_q + 8'd1;
      nx_y       = last_x ? (last_tile ? 8'd0 : tile_y_q + 8'd1) : tile_y_q;
      accept_st  = (state == S_REQ) || (state == S_FILL) || (state == S_DRAIN);
      score_take = bus.match_valid && accept_st && (cnt != PATCHES);
      score_bad  = bus.match_valid && !score_take;
   end

   // Main control: tile sequencing, score counting, best tracking, result handshake.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_IDLE;
         base_q       <= '0;
         cnt          <= '0;
         pos_row      <= '0;
         pos_col      <= '0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
         err_q        <= 1'b0;
         wh_en_q      <= 1'b0;
         tile_valid_q <= 1'b0;
         tile_x_q     <= '0;
         tile_y_q     <= '0;
         best_row_q   <= '0;
         best_col_q   <= '0;
         best_score_q <= '0;
      end else begin
         frame_done_q <= 1'b0;
         if (score_bad) err_q <= 1'b1;
         if (score_take) begin
            cnt <= cnt + 13'd1;
            // First score of a tile always loads; ties keep the earlier position.
            if ((cnt == 13'd0) || (bus.match_score < best_score_q)) begin
               best_score_q <= bus.match_score;
               best_row_q   <= pos_row;
               best_col_q   <= pos_col;
            end
            if (pos_col == LAST_POS) begin
               pos_col <= '0;
               pos_row <= pos_row + 7'd1;
            end else begin
               pos_col <= pos_col + 7'd1;
            end
         end
         case (state)
            S_IDLE: begin
               if (start) begin
                  state    <= S_REQ;
                  busy_q   <= 1'b1;
                  wh_en_q  <= 1'b1;
                  tile_x_q <= '0;
                  tile_y_q <= '0;
                  base_q   <= '0;
                  err_q    <= 1'b0;
                  cnt      <= '0;
                  pos_row  <= '0;
                  pos_col  <= '0;
               end
            end
            S_REQ: begin
               if (bus.wh_ack) begin
                  state   <= S_FILL;
                  wh_en_q <= 1'b0;
               end
            end
            S_FILL: begin
               if (bus.wh_done) state <= S_DRAIN;
            end
            S_DRAIN: begin
               if (cnt == PATCHES) begin
                  state        <= S_RESULT;
                  tile_valid_q <= 1'b1;
               end
            end
            S_RESULT: begin
               if (bus.tile_ready) begin
                  state        <= S_NEXT;
                  tile_valid_q <= 1'b0;
               end
            end
            S_NEXT: begin
               tile_x_q <= nx_x;
               tile_y_q <= nx_y;
               if (last_tile) begin
                  state        <= S_IDLE;
                  busy_q       <= 1'b0;
                  frame_done_q <= 1'b1;
               end else begin
                  state   <= S_REQ;
                  wh_en_q <= 1'b1;
                  base_q  <= ADDR_W'(nx_y) * TILE_ROW_STEP + ADDR_W'(nx_x) * TILE_COL_STEP;
                  cnt     <= '0;
                  pos_row <= '0;
                  pos_col <= '0;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

`ifdef WINDOW_SCHEDULER_STATS_EN
   logic [31:0] frame_cyc_q;
   logic [31:0] stall_cyc_q;

   // Frame length (first REQ cycle through the frame_done cycle) and result stall counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         frame_cyc_q <= '0;
         stall_cyc_q <= '0;
      end else if ((state == S_IDLE) && start) begin
         frame_cyc_q <= '0;
         stall_cyc_q <= '0;
      end else begin
         if ((busy_q || frame_done_q) && (frame_cyc_q != '1)) frame_cyc_q <= frame_cyc_q + 32'd1;
         if ((state == S_RESULT) && !bus.tile_ready && (stall_cyc_q != '1))
            stall_cyc_q <= stall_cyc_q + 32'd1;
      end
   end

   assign stat_frame_cycles = frame_cyc_q;
   assign stat_stall_cycles = stall_cyc_q;
`endif

   assign bus.mem_addr   = base_q + ADDR_W'(bus.wh_row) * STRIDE + ADDR_W'(bus.wh_col);
   assign bus.wh_en      = wh_en_q;
   assign bus.tile_valid = tile_valid_q;
   assign bus.tile_x     = tile_x_q;
   assign bus.tile_y     = tile_y_q;
   assign bus.best_row   = best_row_q;
   assign bus.best_col   = best_col_q;
   assign bus.best_score = best_score_q;
   assign busy           = busy_q;
   assign frame_done     = frame_done_q;
   assign err            = err_q;
   assign dbg_state      = state;
endmodule

// File: doc/window_scheduler.md
# window_scheduler

Frame-level controller for the 80x80 window loader. It tiles the frame into TILES_X x TILES_Y search windows and drives the loader's enable handshake for each tile. It generates the frame word address for every loader fetch and collects one match score per 16x16 patch position (65x65 = 4225 per tile). For each tile it reports the minimum-score position to the downstream tracker through a valid/ready handshake.

## Interface
- TILES_X, 4, tiles per frame row
- TILES_Y, 4, tiles per frame column
- ROW_STRIDE, 320, 32-bit words per frame row (must be >= TILES_X*20)
- ADDR_W, 20, word address width
- SCORE_W, 24, match score width
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a frame; sampled only in IDLE
- busy  out  1  high in every state except IDLE
- frame_done  out  1  one-cycle pulse after the last tile result is accepted
- wh_en  out  1  enable to window loader
- wh_ack  in  1  loader accepted enable
- wh_done  in  1  loader finished last patch of tile
- wh_row  in  7  loader fetch row (0..79)
- wh_col  in  7  loader fetch word column (0..19)
- mem_addr  out  ADDR_W  frame word address for current fetch
- match_valid  in  1  one score per patch, in loader patch order
- match_score  in  SCORE_W  score (lower is better)
- tile_valid  out  1  result available
- tile_ready  in  1  downstream accepts result
- tile_x, tile_y  out  8 each  tile index of result
- best_row, best_col  out  7 each  patch offset of minimum (0..64)
- best_score  out  SCORE_W  minimum score
- err  out  1  sticky: score-count violation; cleared by rst or start

## Operation
- States: IDLE, REQ, FILL, DRAIN, RESULT, NEXT.
- IDLE: on start, clear tile indices, err, and score counter -> REQ.
- REQ: wh_en=1; on wh_ack -> FILL. The tile base is registered on entry: base = tile_y*80*ROW_STRIDE + tile_x*20.
- mem_addr = base + wh_row*ROW_STRIDE + wh_col. It is combinational from registered base and loader row/col, truncated to ADDR_W.
- FILL: each match_valid increments the score counter (13 bits) and advances the position tracker pos_col 0..64, then pos_row. On wh_done -> DRAIN.
- DRAIN: waits until score counter = 4225 -> RESULT.
- Best tracking: the first score of a tile loads best unconditionally. Later scores replace it only if strictly less, so ties keep the earliest position in raster order.
- RESULT: tile_valid=1 and outputs held stable. On tile_valid&tile_ready -> NEXT.
- NEXT: tile_x increments; at TILES_X-1 it wraps to 0 and tile_y increments. If the completed tile was (TILES_X-1, TILES_Y-1): pulse frame_done, go to IDLE. Otherwise clear counter and go to REQ.
- match_valid is accepted in REQ/FILL/DRAIN. In IDLE/RESULT/NEXT it is ignored and sets err.
- A match_valid arriving when the counter is already 4225 is dropped and sets err.
- start outside IDLE is ignored.

## Timing
- Reset: busy, frame_done, wh_en, tile_valid, err = 0. tile_x, tile_y, best_row, best_col, best_score, counters = 0. State = IDLE.
- start high in IDLE at cycle N -> wh_en=1 at N+1.
- The loader acks combinationally, so REQ lasts 1 cycle when wh_ack is already high.
- wh_done in FILL at cycle N with counter already 4225 -> DRAIN at N+1, tile_valid at N+2.
- If wh_done and the 4225th match_valid are in the same cycle, the score is counted and compared first; tile_valid follows 2 cycles later.
- Handshake at cycle N -> NEXT at N+1 -> REQ (wh_en=1) or IDLE with frame_done at N+2.
- tile_valid can stay high indefinitely; no output changes while tile_ready=0.
- rst mid-frame returns to IDLE next cycle with all outputs at reset values; no result or frame_done is emitted.

## Configuration
- WINDOW_SCHEDULER_STATS_EN defined: adds outputs stat_frame_cycles (32) and stat_stall_cycles (32).
  - stat_frame_cycles counts cycles from leaving IDLE to frame_done, inclusive of the frame_done cycle.
  - stat_stall_cycles counts RESULT cycles with tile_ready=0.
  - Both clear on start, hold after the frame, and saturate at all-ones.
- Undefined: the ports and counters are absent; all other behaviour is identical.

## Test plan
- Reset, then TILES_X=TILES_Y=1, start, loader model acks immediately, 4225 scores with minimum 5 at patch index 130 -> best_row=2, best_col=0, best_score=5, tile_valid 2 cycles after wh_done, frame_done 2 cycles after tile_ready.
- Default parameters, tile (2,1), wh_row=3, wh_col=7 -> mem_addr = 1*80*320 + 40 + 3*320 + 7 = 26607.
- All 4225 scores equal 100 -> best_row=0, best_col=0, best_score=100 (tie keeps earliest).
- tile_ready held low 50 cycles -> outputs stable, no wh_en; with STATS_EN, stat_stall_cycles=50.
- 4226 match_valid in one tile -> err=1, best unchanged by the extra score; 4 tiles of 2x2 still complete with frame_done once.
- rst asserted during FILL of tile 1 -> next cycle busy=0, wh_en=0, tile_valid=0. A new start restarts at tile (0,0) with base 0.
